// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the RAM arbiter slice.
//   MAX_PORTS  - upper bound on the number of requesters
//   MAX_ADDR_W - width of the address field in the request bundle
//   MAX_IDX_W  - index width that covers any legal port count
//   mem_req_t  - per-port request bundle {we, be, addr, wdata}
//   idx_width  - index width for a given port count (never below 1)
package ram_arb_pkg;

    localparam int MAX_PORTS  = 8;
    localparam int MAX_ADDR_W = 32;
    localparam int MAX_IDX_W  = $clog2(MAX_PORTS);

    typedef struct packed {
        logic                  we;
        logic [3:0]            be;
        logic [MAX_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
    } mem_req_t;

    // A single-port build still needs a 1-bit index so vectors stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among N requesters.
//   req   in  N   request vector
//   ptr   in  IW  priority pointer; search starts here and wraps
//   gnt   out N   one-hot grant, zero when nothing requests
//   idx   out IW  encoded index of the granted requester
//   valid out 1   some requester was granted
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Requests at or above the pointer get first refusal; if none of those
    // is active, the lowest active request overall wins (the wrap-around).
    logic [N-1:0]  upper_req;
    logic [N-1:0]  first_upper;
    logic [N-1:0]  first_any;
    logic [N:0]    seen_upper;
    logic [N:0]    seen_any;
    logic [IW-1:0] idx_acc [N+1];

    assign seen_upper[0] = 1'b0;
    assign seen_any[0]   = 1'b0;
    assign idx_acc[0]    = '0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pick
            assign upper_req[gi]    = req[gi] & (IW'(gi) >= ptr);
            assign first_upper[gi]  = upper_req[gi] & ~seen_upper[gi];
            assign first_any[gi]    = req[gi] & ~seen_any[gi];
            assign seen_upper[gi+1] = seen_upper[gi] | upper_req[gi];
            assign seen_any[gi+1]   = seen_any[gi] | req[gi];
            assign idx_acc[gi+1]    = idx_acc[gi] | (gnt[gi] ? IW'(gi) : '0);
        end
    endgenerate

    assign gnt   = seen_upper[N] ? first_upper : first_any;
    assign idx   = idx_acc[N];
    assign valid = seen_any[N];

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: N-port round-robin front end for a single-port 32-bit RAM.
//   clk_i, rst_ni            clock / asynchronous active-low reset
//   req_i, we_i, be_i,
//   addr_i, wdata_i          per-port OBI-style request and payload
//   gnt_o                    per-port grant, combinational, one-hot or zero
//   rvalid_o, rdata_o        per-port response; rdata is shared by all ports
//   ram_req_o .. ram_wdata_o muxed request towards the RAM
//   ram_rvalid_i, ram_rdata_i RAM response (one cycle after the request)
//   err_o                    sticky: RAM answered with nothing outstanding
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS-1:0]        we_i,
    input  logic [NUM_PORTS*4-1:0]      be_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
    input  logic [NUM_PORTS*32-1:0]     wdata_i,
    output logic [NUM_PORTS-1:0]        gnt_o,
    output logic [NUM_PORTS-1:0]        rvalid_o,
    output logic [NUM_PORTS*32-1:0]     rdata_o,
    output logic                        ram_req_o,
    output logic                        ram_we_o,
    output logic [3:0]                  ram_be_o,
    output logic [ADDR_W-1:0]           ram_addr_o,
    output logic [31:0]                 ram_wdata_o,
    input  logic                        ram_rvalid_i,
    input  logic [31:0]                 ram_rdata_i,
    output logic                        err_o
);

    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam int REQ_W = $bits(mem_req_t);

    logic [IDX_W-1:0] ptr_q;
    logic             own_valid_q;
    logic [IDX_W-1:0] own_idx_q;
    logic             err_q;

    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic [IDX_W-1:0] ptr_next;

    mem_req_t         port_req [NUM_PORTS];
    logic [REQ_W-1:0] sel_acc  [NUM_PORTS+1];
    mem_req_t         sel_req;

    rr_arbiter #(
        .N  (NUM_PORTS),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .req   (req_i),
        .ptr   (ptr_q),
        .gnt   (gnt_o),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // AND-OR mux driven by the one-hot grant: with no grant every term is
    // zero, which gives the all-zero idle RAM bus for free.
    assign sel_acc[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_req[gi].we    = we_i[gi];
            assign port_req[gi].be    = be_i[gi*4 +: 4];
            assign port_req[gi].addr  = MAX_ADDR_W'(addr_i[gi*ADDR_W +: ADDR_W]);
            assign port_req[gi].wdata = wdata_i[gi*32 +: 32];

            assign sel_acc[gi+1] = sel_acc[gi] | (gnt_o[gi] ? port_req[gi] : '0);

            assign rvalid_o[gi] = ram_rvalid_i & own_valid_q & (own_idx_q == IDX_W'(gi));
            assign rdata_o[gi*32 +: 32] = ram_rdata_i;
        end
    endgenerate

    assign sel_req     = mem_req_t'(sel_acc[NUM_PORTS]);
    assign ram_req_o   = win_valid;
    assign ram_we_o    = sel_req.we;
    assign ram_be_o    = sel_req.be;
    assign ram_addr_o  = sel_req.addr[ADDR_W-1:0];
    assign ram_wdata_o = sel_req.wdata;

    assign ptr_next = (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            own_valid_q <= 1'b0;
            own_idx_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (win_valid) begin
                ptr_q     <= ptr_next;
                own_idx_q <= win_idx;
            end
            own_valid_q <= win_valid;
            // A response with no outstanding access cannot be routed; remember it.
            if (ram_rvalid_i && !own_valid_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NP-1:0]     req_i = '0;
    logic [NP-1:0]     we_i = '0;
    logic [NP*4-1:0]   be_i = '0;
    logic [NP*AW-1:0]  addr_i = '0;
    logic [NP*32-1:0]  wdata_i = '0;
    logic [NP-1:0]     gnt_o;
    logic [NP-1:0]     rvalid_o;
    logic [NP*32-1:0]  rdata_o;
    logic              ram_req_o;
    logic              ram_we_o;
    logic [3:0]        ram_be_o;
    logic [AW-1:0]     ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic              ram_rvalid_i;
    logic [31:0]       ram_rdata_i;
    logic              err_o;

    ram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .ram_req_o    (ram_req_o),
        .ram_we_o     (ram_we_o),
        .ram_be_o     (ram_be_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_rvalid_i (ram_rvalid_i),
        .ram_rdata_i  (ram_rdata_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- demo RAM (not reset, as in the real system) ----------
    logic [31:0] ram_mem [64];
    logic        ram_rvalid_q = 1'b0;
    logic [31:0] ram_rdata_q = '0;
    logic        inject = 1'b0;

    assign ram_rvalid_i = ram_rvalid_q | inject;
    assign ram_rdata_i  = ram_rdata_q;

    always @(posedge clk_i) begin
        ram_rvalid_q <= ram_req_o;
        if (ram_req_o) begin
            ram_rdata_q <= ram_mem[ram_addr_o[7:2]];
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be_o[b]) ram_mem[ram_addr_o[7:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- reference model and scoreboard -----------------------
    typedef struct {
        int          due;
        int          port;
        bit          is_read;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [64];
    int          model_ptr = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [NP-1:0] last_gnt;

    // Pending transaction per requester; held until granted.
    bit          p_valid [NP];
    bit          p_we    [NP];
    logic [3:0]  p_be    [NP];
    logic [31:0] p_addr  [NP];
    logic [31:0] p_wdata [NP];

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 8) return 32'h1122_3344;
        return 32'hA500_0000 ^ (i * 32'h0001_0203);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            req_i[i]             = p_valid[i];
            we_i[i]              = p_we[i];
            be_i[i*4 +: 4]       = p_be[i];
            addr_i[i*AW +: AW]   = p_addr[i];
            wdata_i[i*32 +: 32]  = p_wdata[i];
        end
    endtask

    // Round-robin rule: first requesting port at or after the pointer, wrapping.
    function automatic int winner();
        for (int k = 0; k < NP; k++) begin
            if (p_valid[(model_ptr + k) % NP]) return (model_ptr + k) % NP;
        end
        return -1;
    endfunction

    task automatic set_req(input int p, input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        p_valid[p] = 1'b1;
        p_we[p]    = we;
        p_be[p]    = be;
        p_addr[p]  = addr;
        p_wdata[p] = wdata;
    endtask

    task automatic step();
        int   w;
        exp_t e;
        @(negedge clk_i);
        drive();
        #1;
        w = winner();
        last_gnt = gnt_o;
        check("gnt", 32'(gnt_o), (w >= 0) ? (32'd1 << w) : 32'd0);
        if (w >= 0) begin
            check("ram_req", 32'(ram_req_o), 32'd1);
            check("ram_addr", ram_addr_o, p_addr[w]);
            check("ram_we", 32'(ram_we_o), 32'(p_we[w]));
            if (p_we[w]) check("ram_wdata", ram_wdata_o, p_wdata[w]);
            e.due     = cyc + 1;
            e.port    = w;
            e.is_read = !p_we[w];
            e.rdata   = ref_mem[p_addr[w][7:2]];
            exp_q.push_back(e);
            if (p_we[w]) begin
                for (int b = 0; b < 4; b++) begin
                    if (p_be[w][b]) ref_mem[p_addr[w][7:2]][b*8 +: 8] = p_wdata[w][b*8 +: 8];
                end
            end
            p_valid[w] = 1'b0;
            model_ptr  = (w + 1) % NP;
        end else begin
            check("idle_ram_req", 32'(ram_req_o), 32'd0);
            check("idle_ram_addr", ram_addr_o, 32'd0);
            check("idle_ram_wdata", ram_wdata_o, 32'd0);
        end
    endtask

    // Response monitor: pops the expected response whenever the DUT presents one.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #2;
            if (rst_ni) begin
                if (rvalid_o != '0) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_rvalid", 32'(rvalid_o), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("rsp port=%0d read=%0d rdata=%08h cyc=%0d", e.port, e.is_read,
                                 rdata_o[e.port*32 +: 32], cyc);
                        check("rsp_port", 32'(rvalid_o), 32'd1 << e.port);
                        check("rsp_latency", cyc, e.due);
                        if (e.is_read) check("rsp_rdata", rdata_o[e.port*32 +: 32], e.rdata);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    check("rsp_missing", 32'(rvalid_o), 32'd1 << e.port);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        for (int i = 0; i < NP; i++) set_req(i, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < NP; i++) p_valid[i] = 1'b0;

        // Reset state
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_ram_req", 32'(ram_req_o), 32'd0);
        rst_ni = 1'b1;

        // Single port read of 0x10 -> word 4
        set_req(0, 1'b0, 4'hF, 32'h10, 32'h0);
        step();
        check("single_gnt", 32'(last_gnt), 32'h1);

        // Partial write by port 1, then read back by port 0
        set_req(1, 1'b1, 4'b0011, 32'h20, 32'hAABB_CCDD);
        step();
        check("write_gnt", 32'(last_gnt), 32'h2);
        set_req(0, 1'b0, 4'hF, 32'h20, 32'h0);
        step();
        check("readback_ref", ref_mem[8], 32'h1122_CCDD);

        // Drive pointer to 3, then ports 0 and 3 request: 3 wins, then 0
        set_req(2, 1'b0, 4'hF, 32'h30, 32'h0);
        step();
        set_req(0, 1'b0, 4'hF, 32'h04, 32'h0);
        set_req(3, 1'b0, 4'hF, 32'h08, 32'h0);
        step();
        check("wrap_gnt3", 32'(last_gnt), 32'h8);
        step();
        check("wrap_gnt0", 32'(last_gnt), 32'h1);

        // All ports requesting continuously: each granted once per NP cycles
        for (int c = 0; c < 3 * NP; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!p_valid[i]) set_req(i, 1'b0, 4'hF, {24'h0, 6'(i * 5 + c), 2'b00}, 32'h0);
            end
            step();
        end
        for (int i = 0; i < NP; i++) p_valid[i] = 1'b0;
        step();

        // Randomized traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!p_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                            {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
                end
            end
            step();
        end
        while (p_valid[0] || p_valid[1] || p_valid[2] || p_valid[3]) step();
        step();
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Spurious RAM response with nothing outstanding
        @(negedge clk_i);
        inject = 1'b1;
        #1;
        check("inject_rvalid", 32'(rvalid_o), 32'd0);
        @(negedge clk_i);
        inject = 1'b0;
        check("inject_err", 32'(err_o), 32'd1);
        @(negedge clk_i);
        check("err_sticky", 32'(err_o), 32'd1);
        rst_ni = 1'b0;
        model_ptr = 0;
        #1;
        check("err_cleared", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Pointer back at 0 after reset: all request, port 0 wins
        for (int i = 0; i < NP; i++) set_req(i, 1'b0, 4'hF, 32'(i * 4), 32'h0);
        step();
        check("post_rst_gnt", 32'(last_gnt), 32'h1);
        step();
        step();
        step();
        step();
        step();

        // Reset asserted right after a grant: response dropped, err flagged
        @(negedge clk_i);
        set_req(2, 1'b0, 4'hF, 32'h30, 32'h0);
        drive();
        #1;
        w = winner();
        check("midrst_gnt", 32'(gnt_o), 32'd1 << w);
        p_valid[2] = 1'b0;
        #1;
        rst_ni = 1'b0;
        model_ptr = 0;
        #1;
        check("midrst_rvalid", 32'(rvalid_o), 32'd0);
        check("midrst_err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        drive();
        rst_ni = 1'b1;
        check("midrst_rvalid2", 32'(rvalid_o), 32'd0);
        @(negedge clk_i);
        check("midrst_rvalid3", 32'(rvalid_o), 32'd0);
        check("midrst_err_set", 32'(err_o), 32'd1);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
